// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-write store buffer.
// The merge helper is kept here so that load-forwarding logic can reuse
// exactly the same byte-lane combining rule as store coalescing.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;

    // One buffered store: word address, lane-aligned data, byte enables.
    typedef struct packed {
        logic [SB_ADDR_W-3:0] word_addr;
        logic [31:0]          data;
        logic [3:0]           bwe;
    } sb_entry_t;

    // Result of combining a newer store into an older one.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  bwe;
    } sb_merge_t;

    // Newer bytes win wherever the newer store enables them; enables are ORed.
    function automatic sb_merge_t sb_merge(input logic [31:0] old_data,
                                           input logic [3:0]  old_bwe,
                                           input logic [31:0] new_data,
                                           input logic [3:0]  new_bwe);
        sb_merge_t r;
        r.bwe = old_bwe | new_bwe;
        for (int b = 0; b < 4; b++) begin
            r.data[8*b +: 8] = new_bwe[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/store_buffer.sv
// Four-entry posted-write buffer between the store formatter and the
// data-memory write port. Same-word stores merge into the youngest entry
// (never the head, so an in-flight handshake stays stable), entries drain in
// order, and loads that hit a pending word are flagged for a stall.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_data,
    input  logic [3:0]        in_bwe,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic [3:0]        mem_bwe,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hazard,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TWO_CNT  = CNT_W'(2);

    logic [ADDR_W-3:0] ent_addr [DEPTH];
    logic [31:0]       ent_data [DEPTH];
    logic [3:0]        ent_bwe  [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [PTR_W-1:0]  youngest;
    logic              accept;
    logic              coalesce;
    logic              alloc;
    logic              pop;
    sb_merge_t         merged;

    // Byte-offset bits of both addresses are deliberately ignored.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{in_addr[1:0], ld_addr[1:0]};

    // Status flags come straight from the registered count, no ready bypass.
    assign empty     = (count == '0);
    assign mem_valid = !empty;
    assign in_ready  = (count != FULL_CNT);

    assign mem_addr  = {ent_addr[head], 2'b00};
    assign mem_data  = ent_data[head];
    assign mem_bwe   = ent_bwe[head];

    // Classify this cycle's store as drop, coalesce or allocate, and detect a pop.
    always_comb begin
        youngest = tail - 1'b1;
        accept   = in_valid && in_ready;
        coalesce = accept && (in_bwe != 4'b0000) && (count >= TWO_CNT) &&
                   (ent_addr[youngest] == in_addr[ADDR_W-1:2]);
        alloc    = accept && (in_bwe != 4'b0000) && !coalesce;
        pop      = mem_valid && mem_ready;
        merged   = sb_merge(ent_data[youngest], ent_bwe[youngest], in_data, in_bwe);
    end

    // Conservative load hazard: any valid entry holding the load's word.
    always_comb begin
        logic [PTR_W-1:0] offset;
        ld_hazard = 1'b0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - head;
            if (({1'b0, offset} < count) && (ent_addr[i] == ld_addr[ADDR_W-1:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

    // Queue storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_bwe[i]  <= '0;
            end
        end else begin
            if (alloc) begin
                ent_addr[tail] <= in_addr[ADDR_W-1:2];
                ent_data[tail] <= in_data;
                ent_bwe[tail]  <= in_bwe;
                tail           <= tail + 1'b1;
            end else if (coalesce) begin
                ent_data[youngest] <= merged.data;
                ent_bwe[youngest]  <= merged.bwe;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({alloc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer. Inputs change 1 ns after
// the rising edge; outputs are checked at that same point, away from the edge.
`timescale 1ns/1ps
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [3:0]  in_bwe;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_bwe;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        empty;

    int checks;
    int failures;

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_bwe    (in_bwe),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_bwe   (mem_bwe),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .empty     (empty)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one store for exactly one cycle.
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_bwe   = b;
        tick();
        in_valid = 1'b0;
        in_bwe   = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_bwe    = '0;
        mem_ready = 1'b0;
        ld_addr   = '0;
        #12;
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (mem_valid !== 1'b0)  begin failures++; $display("[TB] FAIL reset_mem_valid got %b want 0", mem_valid); end
        checks++; if (empty !== 1'b1)      begin failures++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
        checks++; if (mem_addr !== 32'h0)  begin failures++; $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (mem_data !== 32'h0)  begin failures++; $display("[TB] FAIL reset_mem_data got %h want 0", mem_data); end
        checks++; if (mem_bwe !== 4'h0)    begin failures++; $display("[TB] FAIL reset_mem_bwe got %h want 0", mem_bwe); end
        checks++; if (ld_hazard !== 1'b0)  begin failures++; $display("[TB] FAIL reset_ld_hazard got %b want 0", ld_hazard); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        mem_ready = 1'b1;
        push(32'h100, 32'hAABBCCDD, 4'b1111);
        checks++; if (mem_valid !== 1'b1)       begin failures++; $display("[TB] FAIL single_valid got %b want 1", mem_valid); end
        checks++; if (mem_addr !== 32'h100)     begin failures++; $display("[TB] FAIL single_addr got %h want 100", mem_addr); end
        checks++; if (mem_data !== 32'hAABBCCDD) begin failures++; $display("[TB] FAIL single_data got %h want aabbccdd", mem_data); end
        checks++; if (mem_bwe !== 4'hF)         begin failures++; $display("[TB] FAIL single_bwe got %h want f", mem_bwe); end
        tick();
        checks++; if (empty !== 1'b1)           begin failures++; $display("[TB] FAIL single_empty_after_pop got %b want 1", empty); end
        mem_ready = 1'b0;
    endtask

    task automatic test_coalesce();
        mem_ready = 1'b0;
        push(32'h200, 32'h00000011, 4'b0001);
        push(32'h204, 32'h00000011, 4'b0001);
        push(32'h205, 32'h00002200, 4'b0010);
        checks++; if (in_ready !== 1'b1)         begin failures++; $display("[TB] FAIL coal_in_ready got %b want 1", in_ready); end
        checks++; if (mem_addr !== 32'h200)      begin failures++; $display("[TB] FAIL coal_head_addr got %h want 200", mem_addr); end
        checks++; if (mem_bwe !== 4'b0001)       begin failures++; $display("[TB] FAIL coal_head_bwe got %b want 0001", mem_bwe); end
        checks++; if (mem_data[7:0] !== 8'h11)   begin failures++; $display("[TB] FAIL coal_head_data got %h want 11", mem_data[7:0]); end
        mem_ready = 1'b1;
        tick();
        checks++; if (mem_addr !== 32'h204)      begin failures++; $display("[TB] FAIL coal_second_addr got %h want 204", mem_addr); end
        checks++; if (mem_bwe !== 4'b0011)       begin failures++; $display("[TB] FAIL coal_second_bwe got %b want 0011", mem_bwe); end
        checks++; if (mem_data[15:0] !== 16'h2211) begin failures++; $display("[TB] FAIL coal_second_data got %h want 2211", mem_data[15:0]); end
        tick();
        checks++; if (empty !== 1'b1)            begin failures++; $display("[TB] FAIL coal_two_entries got empty=%b want 1", empty); end
        mem_ready = 1'b0;
    endtask

    task automatic test_head_no_merge();
        mem_ready = 1'b0;
        push(32'h300, 32'h000000AA, 4'b0001);
        push(32'h300, 32'h0000BB00, 4'b0010);
        checks++; if (mem_bwe !== 4'b0001)       begin failures++; $display("[TB] FAIL head_first_bwe got %b want 0001", mem_bwe); end
        checks++; if (mem_data[7:0] !== 8'hAA)   begin failures++; $display("[TB] FAIL head_first_data got %h want aa", mem_data[7:0]); end
        mem_ready = 1'b1;
        tick();
        checks++; if (mem_valid !== 1'b1)        begin failures++; $display("[TB] FAIL head_second_valid got %b want 1", mem_valid); end
        checks++; if (mem_bwe !== 4'b0010)       begin failures++; $display("[TB] FAIL head_second_bwe got %b want 0010", mem_bwe); end
        checks++; if (mem_data[15:8] !== 8'hBB)  begin failures++; $display("[TB] FAIL head_second_data got %h want bb", mem_data[15:8]); end
        tick();
        checks++; if (empty !== 1'b1)            begin failures++; $display("[TB] FAIL head_count2_empty got %b want 1", empty); end
        mem_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] exp_addr [4];
        logic [31:0] exp_data [4];
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h500 + 32'(4 * i), 32'(i + 1), 4'b1111);
        end
        checks++; if (in_ready !== 1'b0)   begin failures++; $display("[TB] FAIL full_in_ready got %b want 0", in_ready); end
        in_valid = 1'b1;
        in_addr  = 32'h510;
        in_data  = 32'd5;
        in_bwe   = 4'b1111;
        mem_ready = 1'b1;
        checks++; if (in_ready !== 1'b0)   begin failures++; $display("[TB] FAIL full_no_bypass got %b want 0", in_ready); end
        tick();
        mem_ready = 1'b0;
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("[TB] FAIL full_ready_after_pop got %b want 1", in_ready); end
        checks++; if (mem_addr !== 32'h504) begin failures++; $display("[TB] FAIL full_head_after_pop got %h want 504", mem_addr); end
        tick();
        in_valid = 1'b0;
        in_bwe   = 4'b0000;
        checks++; if (in_ready !== 1'b0)   begin failures++; $display("[TB] FAIL full_refilled got %b want 0", in_ready); end
        exp_addr = '{32'h504, 32'h508, 32'h50C, 32'h510};
        exp_data = '{32'd2, 32'd3, 32'd4, 32'd5};
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== exp_addr[i] || mem_data !== exp_data[i]) begin
                failures++;
                $display("[TB] FAIL full_order_%0d got v=%b a=%h d=%h want v=1 a=%h d=%h",
                         i, mem_valid, mem_addr, mem_data, exp_addr[i], exp_data[i]);
            end
            tick();
        end
        checks++; if (empty !== 1'b1)      begin failures++; $display("[TB] FAIL full_drained got %b want 1", empty); end
        mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_addr  = 32'h800 + 32'(16 * i);
            in_data  = 32'hC0DE0000 + 32'(i);
            in_bwe   = 4'b1111;
            tick();
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== (32'h800 + 32'(16 * i)) ||
                mem_data !== (32'hC0DE0000 + 32'(i))) begin
                failures++;
                $display("[TB] FAIL b2b_%0d got v=%b a=%h d=%h want v=1 a=%h d=%h", i,
                         mem_valid, mem_addr, mem_data, 32'h800 + 32'(16 * i), 32'hC0DE0000 + 32'(i));
            end
        end
        in_valid = 1'b0;
        in_bwe   = 4'b0000;
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL b2b_empty got %b want 1", empty); end
        mem_ready = 1'b0;
    endtask

    task automatic test_hazard();
        mem_ready = 1'b0;
        push(32'h400, 32'h12345678, 4'b1111);
        ld_addr = 32'h402;
        #1;
        checks++; if (ld_hazard !== 1'b1) begin failures++; $display("[TB] FAIL hazard_hit got %b want 1", ld_hazard); end
        ld_addr = 32'h404;
        #1;
        checks++; if (ld_hazard !== 1'b0) begin failures++; $display("[TB] FAIL hazard_other_word got %b want 0", ld_hazard); end
        push(32'h600, 32'hFFFFFFFF, 4'b0000);
        ld_addr = 32'h600;
        #1;
        checks++; if (ld_hazard !== 1'b0) begin failures++; $display("[TB] FAIL drop_no_entry got %b want 0", ld_hazard); end
        mem_ready = 1'b1;
        checks++; if (mem_addr !== 32'h400) begin failures++; $display("[TB] FAIL drop_head got %h want 400", mem_addr); end
        tick();
        checks++; if (empty !== 1'b1)     begin failures++; $display("[TB] FAIL drop_count_unchanged got empty=%b want 1", empty); end
        ld_addr = 32'h402;
        #1;
        checks++; if (ld_hazard !== 1'b0) begin failures++; $display("[TB] FAIL hazard_after_pop got %b want 0", ld_hazard); end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        push(32'h700, 32'd7, 4'b1111);
        push(32'h704, 32'd8, 4'b1111);
        push(32'h708, 32'd9, 4'b1111);
        ld_addr   = 32'h708;
        mem_ready = 1'b1;
        tick();
        #2;
        checks++; if (ld_hazard !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_hazard got %b want 1", ld_hazard); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid got %b want 0", mem_valid); end
        checks++; if (ld_hazard !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_hazard got %b want 0", ld_hazard); end
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("[TB] FAIL mid_reset_ready got %b want 1", in_ready); end
        checks++; if (empty !== 1'b1)     begin failures++; $display("[TB] FAIL mid_reset_empty got %b want 1", empty); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_after_release got %b want 0", mem_valid); end
        mem_ready = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_coalesce();
        test_head_no_merge();
        test_full();
        test_back_to_back();
        test_hazard();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout got running want finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Four-entry posted-write buffer between the store formatter (byte enables plus lane-aligned data) and the data-memory write port. It accepts formatted stores at one per cycle and merges a store into the youngest pending entry when both target the same word. It drains entries in order to memory over a valid/ready handshake and flags loads that hit a pending word so the pipeline can stall them.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  formatted store offered.
- in_ready  out  1  buffer can accept; registered, equals !full.
- in_addr  in  ADDR_W  byte address of the store; bits [1:0] are ignored.
- in_data  in  32  lane-aligned write data.
- in_bwe  in  4  byte write enables; 0 means no write.
- mem_valid  out  1  head entry presented to memory.
- mem_ready  in  1  memory accepts head.
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- mem_data  out  32  head data.
- mem_bwe  out  4  head byte enables; never 0 while mem_valid is high.
- ld_addr  in  ADDR_W  address of the load in the execute stage.
- ld_hazard  out  1  combinational; high if a valid entry has the same word as ld_addr.
- empty  out  1  no valid entries; used by fence and halt logic.

## Operation
- Storage is a circular queue with head and tail pointers and a count of width log2(DEPTH)+1. Each entry holds addr[ADDR_W-1:2], data[31:0] and bwe[3:0].
- Accept happens when in_valid && in_ready.
  - If in_bwe == 0 the store is consumed and dropped. No state changes.
  - If count >= 2 and in_addr[ADDR_W-1:2] equals the youngest entry's word address, the store coalesces:
    - For each byte b with in_bwe[b] set, data byte b is overwritten with in_data byte b.
    - The entry's bwe becomes old bwe | in_bwe.
    - Count and tail are unchanged.
  - Otherwise a new entry is written at tail, tail advances, and count increments.
- The head entry is never coalesced into. When count == 1, a same-word store allocates a new entry, so mem_* stays stable during the handshake.
- Pop happens when mem_valid && mem_ready. Head advances and count decrements.
- mem_valid = (count != 0). mem_addr, mem_data and mem_bwe are driven from the head entry and hold stable until accepted.
- Simultaneous accept and pop:
  - Both take effect.
  - When count == 2, a coalesce into the youngest entry is still legal during the head pop.
  - When full, in_ready is 0 even if mem_ready is 1. There is no combinational ready bypass.
- ld_hazard = OR over valid entries of (entry.addr == ld_addr[ADDR_W-1:2]). The check is conservative: byte overlap is not examined, and stores being accepted in the current cycle are not included.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (rst_n low, asynchronous) puts the block in this state:
  - count = 0, head = tail = 0, all entry fields = 0.
  - in_ready = 1, mem_valid = 0, empty = 1, mem_addr/data/bwe = 0.
  - ld_hazard = 0.
- Releasing rst_n takes effect at the next rising edge. Reset in mid-operation discards all pending stores, including a head whose handshake is in progress.
- Latency from accept to mem_valid is 1 cycle when the buffer was empty. A coalesced store is visible in the entry's fields the cycle after accept.
- Throughput is 1 accept and 1 pop per cycle, so a full buffer drained at mem_ready = 1 sustains one store per cycle after the first pop.
- in_ready, mem_valid and empty are functions of registered count only. ld_hazard is the only output combinational in an input.

## Structure
- Shared package `store_buffer_pkg` holds:
  - SB_DEPTH;
  - the entry struct `sb_entry_t` {word_addr, data, bwe};
  - the function `sb_merge(old_data, old_bwe, new_data, new_bwe)`, which returns the merged data and bwe and is reused by any later load-forwarding logic.
- The block is one module. No sub-module is required.

## Test plan
- Reset, then a single store (addr 0x100, data 0xAABBCCDD, bwe 4'b1111) with mem_ready = 1 → the next cycle shows mem_valid = 1, mem_addr = 0x100, mem_bwe = 4'hF. After the pop: empty = 1.
- mem_ready = 0, then stores to 0x200 (SB 0x11 at lane 0) followed by a store to 0x204 and SB 0x22 to 0x205 (lane 1) → the second and third coalesce. Draining gives 2 entries, the second with bwe = 4'b0011 and data[15:0] = 0x2211.
- mem_ready = 0, one store to 0x300 (bwe 0001), then a store to 0x300 (bwe 0010) → a new entry is allocated because the head is never merged. Count = 2, and the first drain shows bwe = 0001.
- mem_ready = 0, 4 stores to distinct words → in_ready = 0 on the fifth cycle. Then mem_ready = 1 for one cycle → in_ready = 1 the next cycle, and the data order is preserved.
- Pending entry at 0x400, ld_addr = 0x402 → ld_hazard = 1. After the pop, ld_hazard = 0. A store with in_bwe = 0 is accepted and count is unchanged.
- rst_n dropped asynchronously mid-drain with 3 entries → mem_valid and ld_hazard go to 0 immediately, and in_ready = 1.
